// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master side drives the request; the adder is the slave.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, carry
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, carry
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock through a full adder, LSB first,
// with the carry fed back through a flop and the sum reassembled in a shift register.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             c_q, c_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  logic fa_sum;
  logic fa_carry;

  // Full adder cell on the current LSB pair and the fed-back carry.
  always_comb begin
    fa_sum   = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    fa_carry = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sum_d    = sum_q;
    carry_d  = carry_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d              = a_sh_q >> 1;
        b_sh_d              = b_sh_q >> 1;
        sum_sh_d            = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1]   = fa_sum;
        c_d                 = fa_carry;
        cnt_d               = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          // Final bit lands in the result together with this edge's sum bit.
          sum_d   = sum_sh_d;
          carry_d = fa_carry;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed handshake/reset scenarios plus random
// operands checked against plain integer addition.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {carry,sum} = a + b + cin in WIDTH+1 bits.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    return r;
  endfunction

  // Called at a negedge with the DUT idle (or in its done cycle). Returns the result
  // seen in the done cycle, the latency in edges, busy count and done count in the run.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       output logic [W-1:0] s, output logic c, output int lat,
                       output int busy_n, output int done_n);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat    = -1;
    busy_n = (bus.busy === 1'b1) ? 1 : 0;
    done_n = (bus.done === 1'b1) ? 1 : 0;
    s      = 'x;
    c      = 1'bx;
    for (int i = 1; i <= int'(W) + 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_n++;
        lat = i;
        s   = bus.sum;
        c   = bus.carry;
        break;
      end
      if (bus.busy === 1'b1) busy_n++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    bus.cin   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.sum, bus.carry} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h carry=%b want 0 0 00 0",
               bus.busy, bus.done, bus.sum, bus.carry);
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle: got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_zero();
    logic [W-1:0] s;
    logic c;
    int lat, bn, dn;
    do_op(8'h00, 8'h00, 1'b0, s, c, lat, bn, dn);
    total++;
    if (lat !== int'(W) || bn !== int'(W) || dn !== 1) begin
      bad++;
      $display("FAIL zero_timing: got lat=%0d busy_cycles=%0d dones=%0d want %0d %0d 1",
               lat, bn, dn, W, W);
    end
    total++;
    if ({c, s} !== 9'h000) begin
      bad++;
      $display("FAIL zero_result: got %b_%h want 0_00", c, s);
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse_width: got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_carry();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vc [4];
    logic [W-1:0] s;
    logic c;
    logic [W:0] exp;
    int lat, bn, dn;
    va = '{8'hFF, 8'h3C, 8'hA5, 8'hFF};
    vb = '{8'h01, 8'h42, 8'h5A, 8'hFF};
    vc = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      exp = ref_add(va[i], vb[i], vc[i]);
      do_op(va[i], vb[i], vc[i], s, c, lat, bn, dn);
      total++;
      if ({c, s} !== exp || lat !== int'(W)) begin
        bad++;
        $display("FAIL carry_case%0d: got %b_%h lat=%0d want %b_%h lat=%0d",
                 i, c, s, lat, exp[W], exp[W-1:0], W);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_handshake_hold();
    int dn;
    int lat;
    logic [W-1:0] s;
    logic c;
    logic [W:0] exp;
    exp       = ref_add(8'h5E, 8'h27, 1'b0);
    bus.start = 1'b1;
    bus.a     = 8'h5E;
    bus.b     = 8'h27;
    bus.cin   = 1'b0;
    @(posedge clk);
    dn  = 0;
    lat = -1;
    for (int i = 1; i <= int'(W) + 4; i++) begin
      if (i == 4) bus.a = 8'h11;
      @(posedge clk);
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dn++;
        lat = i;
        s   = bus.sum;
        c   = bus.carry;
        bus.start = 1'b0;
        break;
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    total++;
    if ({c, s} !== exp || lat !== int'(W)) begin
      bad++;
      $display("FAIL hold_start_result: got %b_%h lat=%0d want %b_%h lat=%0d",
               c, s, lat, exp[W], exp[W-1:0], W);
    end
    total++;
    if (dn !== 1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_start_single_done: got dones=%0d busy=%b want 1 0", dn, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s;
    logic c;
    int lat, bn, dn;
    do_op(8'h77, 8'h88, 1'b0, s, c, lat, bn, dn);
    total++;
    if ({c, s} !== 9'h0FF) begin
      bad++;
      $display("FAIL b2b_first: got %b_%h want 0_ff", c, s);
    end
    // Still in the done cycle: the next start must be accepted immediately.
    do_op(8'h01, 8'h02, 1'b0, s, c, lat, bn, dn);
    total++;
    if ({c, s} !== 9'h003 || lat !== int'(W) || dn !== 1) begin
      bad++;
      $display("FAIL b2b_second: got %b_%h lat=%0d dones=%0d want 0_03 lat=%0d dones=1",
               c, s, lat, dn, W);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] s;
    logic c;
    int lat, bn, dn;
    int seen;
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'h01;
    bus.cin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.sum, bus.carry} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b sum=%h carry=%b want 0 0 00 0",
               bus.busy, bus.done, bus.sum, bus.carry);
    end
    rst_n = 1'b1;
    seen  = 0;
    repeat (int'(W) + 2) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reset_mid_no_done: got %0d active cycles want 0", seen);
    end
    do_op(8'h10, 8'h20, 1'b0, s, c, lat, bn, dn);
    total++;
    if ({c, s} !== 9'h030 || lat !== int'(W)) begin
      bad++;
      $display("FAIL reset_mid_restart: got %b_%h lat=%0d want 0_30 lat=%0d", c, s, lat, W);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, s;
    logic rc, c;
    logic [W:0] exp;
    int lat, bn, dn, gap;
    for (int n = 0; n < 40; n++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rc  = 1'($urandom);
      exp = ref_add(ra, rb, rc);
      do_op(ra, rb, rc, s, c, lat, bn, dn);
      total++;
      if ({c, s} !== exp || lat !== int'(W)) begin
        bad++;
        $display("FAIL random%0d %h+%h+%b: got %b_%h lat=%0d want %b_%h lat=%0d",
                 n, ra, rb, rc, c, s, lat, exp[W], exp[W-1:0], W);
      end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        total++;
        if ({bus.carry, bus.sum} !== exp || bus.done !== 1'b0) begin
          bad++;
          $display("FAIL random%0d_hold: got %b_%h done=%b want %b_%h done=0",
                   n, bus.carry, bus.sum, bus.done, exp[W], exp[W-1:0]);
        end
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    @(negedge clk);
    test_reset();
    test_zero();
    test_carry();
    test_handshake_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around the team's 1-bit full adder cell (FA: ports a, b, c, sum, carry).
- Sits directly upstream of and around that cell:
  - loads two parallel operands and a carry-in;
  - feeds one bit pair per clock, LSB first, into FA;
  - registers FA's carry back into c;
  - reassembles the sum bits into a parallel result.
- Gives a small-area alternative to a ripple-carry chain, with a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 1 to 32).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result; holds until the next completion.
- carry  output  1  registered carry-out; holds with sum.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; busy=0; done=0; sum=0; carry=0.
  - Internal shift registers, carry flop and bit counter are cleared.
  - Reset overrides every other input.
- States: IDLE, RUN.
  - done is a registered pulse, not a separate state.
- IDLE:
  - done is driven 0 on every edge that does not complete an operation.
  - If start=1 at edge k:
    - a_sh<=a, b_sh<=b, c_reg<=cin, cnt<=0, busy<=1;
    - go RUN.
  - Otherwise remain in IDLE.
- RUN (edges k+1 .. k+WIDTH):
  - FA inputs are a_sh[0], b_sh[0], c_reg.
  - On each edge:
    - a_sh and b_sh shift right by 1;
    - sum_sh shifts right with FA.sum inserted at the MSB;
    - c_reg<=FA.carry;
    - cnt<=cnt+1.
- Completion (edge k+WIDTH, i.e. cnt==WIDTH-1):
  - sum<=final sum_sh value, including this edge's bit;
  - carry<=FA.carry;
  - done<=1; busy<=0; state<=IDLE.
- Latency:
  - done is high in the cycle after edge k+WIDTH, i.e. WIDTH+1 edges after the accepting edge.
  - Throughput is one operation per WIDTH+1 cycles.
- Arithmetic: {carry,sum} = a + b + cin, computed modulo 2^(WIDTH+1). No overflow flag.
- start while busy=1 is ignored; no queuing.
- a, b and cin changes during RUN are ignored; the captured values are used.
- start=1 in the cycle done=1 is accepted (state is IDLE):
  - back-to-back operation;
  - done drops to 0 on that accepting edge.
- sum/carry change only on a completion edge or on reset; they are stable otherwise.
- Reset mid-RUN:
  - aborts the operation;
  - no done pulse; outputs go to 0;
  - the next start proceeds normally.
- WIDTH=1: RUN lasts exactly one edge; done one edge after acceptance +1, per the rule above.
- cnt width: clog2(WIDTH)+1 bits. No combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with start=1 -> busy=0, done=0, sum=8'h00, carry=0. Release -> still IDLE until start is sampled.
- Zero add: a=8'h00, b=8'h00, cin=0, start pulsed at edge k -> busy=1 for edges k+1..k+8; done=1 exactly one cycle after edge k+8; sum=8'h00, carry=0.
- Carry ripple: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, carry=1. Then a=8'h3C, b=8'h42, cin=1 -> sum=8'h7F, carry=0.
- Carry-in full propagate: a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, carry=1. Also check a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, carry=1.
- Handshake:
  - start held high through RUN, with a changed to 8'h11 at the 4th RUN cycle -> result uses the original operands, and only one done pulse per operation.
  - start=1 during the done cycle with a=8'h01, b=8'h02, cin=0 -> accepted immediately; next done gives sum=8'h03, carry=0.
- Reset mid-operation: start a=8'hFF, b=8'h01; assert rst_n=0 at the 4th RUN edge -> busy=0, sum=0, carry=0, no done. A new start with a=8'h10, b=8'h20, cin=0 -> sum=8'h30, carry=0 after 9 edges.
